uart_tx_feeder: RTL

- Byte FIFO with a handshake FSM that sits directly upstream of the UART transmitter.
- Accepts bytes from the system at clk rate and drives the transmitter's TX_in/TX_ctr pair.
- Watches the transmitter's TX_rdy/TX_idle to pace bytes, so multi-byte messages go out back-to-back with no gap stop bits.

---
 rtl/uart_tx_feeder_if.sv | 34 +++
 rtl/uart_tx_feeder.sv | 137 +++++++++++++
 2 files changed

// File: rtl/uart_tx_feeder_if.sv
// Bus between the system-side writer / UART transmitter and uart_tx_feeder.
//   wr_en, wr_data        : byte push from the system
//   full, empty, count    : FIFO occupancy (count excludes the byte held in TX_in)
//   overflow, busy        : sticky push-while-full flag, activity flag
//   TX_in, TX_ctr         : byte and send request toward the transmitter
//   TX_rdy, TX_idle       : transmitter status, baud-clock domain origin
// slave is the feeder's view; master is the environment (system + transmitter).
interface uart_tx_feeder_if #(
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          wr_en;
  logic [7:0]    wr_data;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          overflow;
  logic          busy;
  logic [7:0]    TX_in;
  logic          TX_ctr;
  logic          TX_rdy;
  logic          TX_idle;

  modport slave (
    input  wr_en, wr_data, TX_rdy, TX_idle,
    output full, empty, count, overflow, busy, TX_in, TX_ctr
  );

  modport master (
    output wr_en, wr_data, TX_rdy, TX_idle,
    input  full, empty, count, overflow, busy, TX_in, TX_ctr
  );
endinterface

// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus handshake FSM feeding a UART transmitter back-to-back.
//   clk      : system clock (also drives the transmitter's baud generator)
//   FIFO_rst : synchronous active-high reset
//   bus      : uart_tx_feeder_if.slave (push side, status, TX_in/TX_ctr, TX_rdy/TX_idle)
// A byte is handed over by loading TX_in and holding TX_ctr; the transmitter
// taking it is seen as a falling edge of the synchronised TX_rdy.
module uart_tx_feeder #(
  parameter int unsigned DEPTH = 16
) (
  input  logic              clk,
  input  logic              FIFO_rst,
  uart_tx_feeder_if.slave   bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count_q, count_nxt;
  logic          empty_q, full_q, overflow_q, busy_q;
  logic [7:0]    tx_in_q;
  logic          tx_ctr_q, tx_ctr_nxt;
  logic          rdy_meta, rdy_s, rdy_q, idle_meta, idle_s;
  logic          accept, push, load;

  // Two-flop synchronisers for transmitter status plus edge-detect delay
  always_ff @(posedge clk) begin
    if (FIFO_rst) begin
      rdy_meta  <= 1'b1;
      rdy_s     <= 1'b1;
      rdy_q     <= 1'b1;
      idle_meta <= 1'b1;
      idle_s    <= 1'b1;
    end else begin
      rdy_meta  <= bus.TX_rdy;
      rdy_s     <= rdy_meta;
      rdy_q     <= rdy_s;
      idle_meta <= bus.TX_idle;
      idle_s    <= idle_meta;
    end
  end

  // Transmitter has latched TX_in when its ready drops
  assign accept = rdy_q & ~rdy_s;

  // Full blocks the write even if a pop happens in the same cycle
  assign push      = bus.wr_en & ~full_q;
  assign count_nxt = count_q + CW'(push) - CW'(load);

  // FSM next-state and output decode
  always_comb begin
    state_nxt  = state;
    tx_ctr_nxt = tx_ctr_q;
    load       = 1'b0;
    unique case (state)
      IDLE: begin
        tx_ctr_nxt = 1'b0;
        if (!empty_q) begin
          load       = 1'b1;
          tx_ctr_nxt = 1'b1;
          state_nxt  = REQ;
        end
      end
      REQ: begin
        tx_ctr_nxt = 1'b1;
        if (accept) begin
          if (!empty_q) begin
            load = 1'b1;
          end else begin
            tx_ctr_nxt = 1'b0;
            state_nxt  = DRAIN;
          end
        end
      end
      DRAIN: begin
        tx_ctr_nxt = 1'b0;
        if (!empty_q) begin
          load       = 1'b1;
          tx_ctr_nxt = 1'b1;
          state_nxt  = REQ;
        end else if (idle_s) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        tx_ctr_nxt = 1'b0;
        state_nxt  = IDLE;
      end
    endcase
  end

  // FIFO storage; contents need no reset since pointers gate every read
  always_ff @(posedge clk) begin
    if (!FIFO_rst && push) mem[wptr] <= bus.wr_data;
  end

  // Pointers, occupancy flags, FSM state and transmitter-facing registers
  always_ff @(posedge clk) begin
    if (FIFO_rst) begin
      state      <= IDLE;
      wptr       <= '0;
      rptr       <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      tx_in_q    <= 8'h00;
      tx_ctr_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      tx_ctr_q <= tx_ctr_nxt;
      count_q  <= count_nxt;
      empty_q  <= (count_nxt == '0);
      full_q   <= (count_nxt == CW'(DEPTH));
      busy_q   <= (state_nxt != IDLE) || (count_nxt != '0);
      if (push) wptr <= wptr + AW'(1);
      if (load) begin
        tx_in_q <= mem[rptr];
        rptr    <= rptr + AW'(1);
      end
      if (bus.wr_en && full_q) overflow_q <= 1'b1;
    end
  end

  assign bus.full     = full_q;
  assign bus.empty    = empty_q;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;
  assign bus.busy     = busy_q;
  assign bus.TX_in    = tx_in_q;
  assign bus.TX_ctr   = tx_ctr_q;

endmodule
